// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the 4096x12 memory responder and its CPU control.
package mem_responder_pkg;
  localparam int WORD_W    = 12;
  localparam int ADDR_W    = 12;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    PANEL = 2'd3
  } mem_state_t;

  // CPU request captured at acceptance; both strobes high is treated as a write
  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } cpu_req_t;
endpackage

// File: rtl/mem_array.sv
// Single-port 4096x12 storage: synchronous write, registered read that holds
// its value until the next read.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  // Contents are deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)           rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// CPU memory responder with programmable wait states and a front-panel deposit
// path that takes priority over CPU requests in IDLE.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [11:0] mem_addr,
  input  logic [11:0] mem_wdata,
  output logic        mem_valid,
  output logic [11:0] mem_rdata,
  input  logic        panel_wr,
  input  logic [11:0] panel_addr,
  input  logic [11:0] panel_data,
  output logic        panel_ack,
  output logic        busy,
  output logic        proto_err
);

  mem_state_t        state, state_nx;
  logic [3:0]        cnt;
  cpu_req_t          req_q;
  logic              req_any;
  logic              accept;

  logic              arr_en, arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [WORD_W-1:0] arr_wdata;

  assign req_any = mem_read | mem_write;
  assign accept  = (state == IDLE) && !panel_wr && req_any;

  always_comb begin
    state_nx  = state;
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = req_q.addr;
    arr_wdata = req_q.wdata;
    case (state)
      IDLE: begin
        if (panel_wr)     state_nx = PANEL;
        else if (req_any) state_nx = BUSY;
      end
      BUSY: begin
        if (!req_any) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          arr_en   = 1'b1;
          arr_we   = req_q.is_write;
          state_nx = RESP;
        end
      end
      RESP: state_nx = IDLE;
      PANEL: begin
        arr_en    = 1'b1;
        arr_we    = 1'b1;
        arr_addr  = panel_addr;
        arr_wdata = panel_data;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_q     <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_q     <= '{is_write: mem_write, addr: mem_addr, wdata: mem_wdata};
        cnt       <= 4'(WAIT_STATES);
        if (mem_read && mem_write) proto_err <= 1'b1;
      end else if (state == BUSY && req_any && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Reset in the access cycle must not let a pending write land
  mem_array #(.INIT_FILE(INIT_FILE)) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (arr_en & ~reset),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (mem_rdata)
  );

  assign mem_valid = (state == RESP);
  assign panel_ack = (state == PANEL);
  assign busy      = (state != IDLE);

endmodule
